// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encodings and
// control-bus bit positions so every stage packs and unpacks identically.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_BRANCH_LSB = 3;
  localparam int CTRL_BRANCH_MSB = 5;
  localparam int CTRL_JUMP       = 6;
  localparam int CTRL_MEM_SIZE_LSB = 7;
  localparam int CTRL_MEM_SIZE_MSB = 8;
  localparam int CTRL_MEM_SIGNED = 9;
  localparam int CTRL_WB_SEL_LSB = 10;
  localparam int CTRL_WB_SEL_MSB = 11;

  // The skid entry is only ever filled behind a valid main entry.
  function automatic occ_e occ_of(input logic mainValid, input logic skidValid);
    if (skidValid) return OCC_FULL;
    if (mainValid) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_entry_reg.sv
// One payload + control + valid holding register. Payload only changes on an
// actual capture, so a held or dropped entry keeps its last data.
module pipe_entry_reg
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        ctrl_d = ctrl_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry valid/ready pipeline stage register (main + skid) with flush and
// bubble control zeroing.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              mainValid, skidValid;
  logic [DATA_W-1:0] mainData, skidData;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;
  logic              inFire, outFire;
  logic              mainLoad, mainNextValid;
  logic              skidLoad, skidNextValid;
  logic [DATA_W-1:0] mainSrcData;
  logic [CTRL_W-1:0] mainSrcCtrl;

  assign in_ready = !skidValid && rst_n;
  assign inFire   = in_valid && in_ready;
  assign outFire  = mainValid && out_ready;

  // Main refills whenever it is empty or drained; the skid entry has priority
  // over the input so arrival order is preserved.
  assign mainLoad      = !mainValid || outFire;
  assign mainNextValid = skidValid || inFire;
  assign mainSrcData   = skidValid ? skidData : in_data;
  assign mainSrcCtrl   = skidValid ? skidCtrl : in_ctrl;

  // Skid captures only when main is stalled, and empties when main drains it.
  assign skidLoad      = (mainValid && !out_ready && inFire) || (skidValid && out_ready);
  assign skidNextValid = !skidValid;

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .load_i  (mainLoad),
    .valid_i (mainNextValid),
    .data_i  (mainSrcData),
    .ctrl_i  (mainSrcCtrl),
    .valid_o (mainValid),
    .data_o  (mainData),
    .ctrl_o  (mainCtrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush),
    .load_i  (skidLoad),
    .valid_i (skidNextValid),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skidValid),
    .data_o  (skidData),
    .ctrl_o  (skidCtrl)
  );

  assign out_valid = mainValid;
  assign out_ctrl  = mainValid ? mainCtrl : '0;
  assign out_data  = (CLEAR_DATA && !mainValid) ? '0 : mainData;
  assign occupancy = occ_of(mainValid, skidValid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scenario bench for pipe_stage_skid; a second instance with CLEAR_DATA=1
// shares all inputs so bubble data clearing can be observed side by side.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_ready;

  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  logic              c_in_ready, c_out_valid;
  logic [DATA_W-1:0] c_out_data;
  logic [CTRL_W-1:0] c_out_ctrl;
  logic [1:0]        c_occupancy;

  int checks = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1'b1)) dutClr (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data), .out_ctrl(c_out_ctrl),
    .occupancy(c_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_ctrl !== '0) begin failures++; $display("[TB] FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); end
    #4;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== vals[i]) begin failures++; $display("[TB] FAIL stream_data[%0d] got=%h exp=%h", i, out_data, vals[i]); end
      checks++; if (out_ctrl !== 16'h0001) begin failures++; $display("[TB] FAIL stream_ctrl[%0d] got=%h exp=0001", i, out_ctrl); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("[TB] FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL stream_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'h0002;
    tick();
    in_data = 64'hB; in_ctrl = 16'h0004;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL stall_occ[%0d] got=%0d exp=2", i, occupancy); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      checks++; if (out_data !== 64'hA) begin failures++; $display("[TB] FAIL stall_hold_data[%0d] got=%h exp=a", i, out_data); end
      checks++; if (out_ctrl !== 16'h0002) begin failures++; $display("[TB] FAIL stall_hold_ctrl[%0d] got=%h exp=0002", i, out_ctrl); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 64'hB || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_second got=%h/%b exp=b/1", out_data, out_valid); end
    checks++; if (out_ctrl !== 16'h0004) begin failures++; $display("[TB] FAIL stall_second_ctrl got=%h exp=0004", out_ctrl); end
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin failures++; $display("[TB] FAIL stall_release got=%b/%0d exp=1/1", in_ready, occupancy); end
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("[TB] FAIL stall_drain got=%b/%0d exp=0/0", out_valid, occupancy); end
  endtask

  task automatic test_bubble();
    in_valid = 1'b0; in_ctrl = 16'hFFFF; in_data = 64'h1234; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bubble_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 16'h0000) begin failures++; $display("[TB] FAIL bubble_ctrl got=%h exp=0000", out_ctrl); end
    checks++; if (out_data !== 64'hB) begin failures++; $display("[TB] FAIL bubble_data_held got=%h exp=b", out_data); end
    checks++; if (c_out_data !== '0) begin failures++; $display("[TB] FAIL bubble_data_cleared got=%h exp=0", c_out_data); end
    checks++; if (c_out_ctrl !== '0) begin failures++; $display("[TB] FAIL bubble_ctrl_cleared got=%h exp=0", c_out_ctrl); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h50; in_ctrl = 16'h0001;
    tick();
    flush = 1'b1; in_data = 64'hC; in_ctrl = 16'h0008;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_one got=%0d/%b exp=0/0", occupancy, out_valid); end
    checks++; if (out_data !== 64'h50) begin failures++; $display("[TB] FAIL flush_one_data got=%h exp=50", out_data); end

    in_valid = 1'b1; in_data = 64'hD0; in_ctrl = 16'h0010;
    tick();
    in_data = 64'hD1;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL flush_prefill got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 64'hC; in_ctrl = 16'h0008;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (occupancy !== 2'd0) begin failures++; $display("[TB] FAIL flush_full_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin failures++; $display("[TB] FAIL flush_full_out got=%b/%h exp=0/0", out_valid, out_ctrl); end
    checks++; if (out_data !== 64'hD0) begin failures++; $display("[TB] FAIL flush_full_data got=%h exp=d0", out_data); end
    checks++; if (c_out_data !== '0) begin failures++; $display("[TB] FAIL flush_clear_data got=%h exp=0", c_out_data); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_after[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE0; in_ctrl = 16'h0020;
    tick();
    in_data = 64'hE1;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2) begin failures++; $display("[TB] FAIL areset_prefill got=%0d exp=2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("[TB] FAIL areset_state got=%b/%0d exp=0/0", out_valid, occupancy); end
    checks++; if (out_data !== '0 || out_ctrl !== '0) begin failures++; $display("[TB] FAIL areset_payload got=%h/%h exp=0/0", out_data, out_ctrl); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL areset_in_ready got=%b exp=0", in_ready); end
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_release got=%b exp=1", in_ready); end
    tick();
  endtask

  // Reference is an ordered queue of at most two entries; outputs are the head.
  task automatic test_random();
    int mq[$];
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    bit expReady, outF, inF;
    while (recv < 1000 && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = DATA_W'(sent);
      in_ctrl   = CTRL_W'(sent);
      out_ready = ($urandom_range(0, 1) == 1);
      #4;
      expReady = (mq.size() < 2);
      checks++; if (in_ready !== expReady) begin failures++; $display("[TB] FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, expReady); end
      checks++; if (occupancy !== 2'(mq.size())) begin failures++; $display("[TB] FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, mq.size()); end
      checks++; if (out_valid !== (mq.size() > 0)) begin failures++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, mq.size() > 0); end
      if (out_valid === 1'b1 && out_ready) begin
        checks++; if (out_data !== DATA_W'(recv)) begin failures++; $display("[TB] FAIL rand_order cyc=%0d got=%h exp=%h", cyc, out_data, DATA_W'(recv)); end
        checks++; if (out_ctrl !== CTRL_W'(recv)) begin failures++; $display("[TB] FAIL rand_ctrl cyc=%0d got=%h exp=%h", cyc, out_ctrl, CTRL_W'(recv)); end
        recv++;
      end
      outF = (mq.size() > 0) && out_ready;
      inF  = in_valid && expReady;
      if (outF) void'(mq.pop_front());
      if (inF) begin
        mq.push_back(sent);
        sent++;
      end
      cyc++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (recv != 1000) begin failures++; $display("[TB] FAIL rand_timeout got=%0d exp=1000", recv); end
  endtask

  initial begin
    test_reset();
    tick();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field stage registers (ID/EX, EX/MEM, MEM/WB).
- A two-entry pipeline stage register carrying a generic payload bus plus a control bus, with valid/ready flow control, stall absorption via a skid entry, and synchronous flush.
- The control bus is forced to zero whenever no valid entry is presented, so a bubble can never write registers or memory.
- It sits between any two pipeline stages; the core instantiates one per stage boundary.

Parameters:
- DATA_W, 64: payload width (ALU result, store data, PC, register indices, concatenated by the instantiating stage).
- CTRL_W, 16: control-bit width (reg_write, mem_write, branch, etc.); zeroed on bubble/flush.
- CLEAR_DATA, 0: if 1, out_data also reads zero when out_valid=0; if 0, out_data holds its last value.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all held entries (branch/jump redirect).
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  stage presents an entry downstream.
- out_ready  in  1  downstream accepts; low = stall.
- out_data  out  DATA_W  presented payload.
- out_ctrl  out  CTRL_W  presented control; all zero when out_valid=0.
- occupancy  out  2  entries held (0, 1 or 2).

Behaviour:
- Handshake and latency:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - Latency is 1 cycle: an entry captured on edge N is visible on out_* after edge N.
  - Throughput is 1 entry/cycle while out_ready=1.
  - Entries leave in arrival order.
- Storage is a main entry (drives the outputs) and a skid entry.
- States (occupancy):
  - EMPTY (0)
  - ONE (1): main valid.
  - FULL (2): main and skid valid.
- Outputs:
  - out_valid = main_valid.
  - in_ready = !skid_valid & rst_n, i.e. 1 in EMPTY and ONE, 0 in FULL and while reset is asserted.
  - out_ctrl = main_valid ? main_ctrl : 0.
  - out_data = (CLEAR_DATA & !main_valid) ? 0 : main_data.
- Transitions (flush=0):
  - EMPTY, in_fire -> ONE, main <= in.
  - EMPTY, no fire -> EMPTY.
  - ONE, in_fire & out_fire -> ONE, main <= in.
  - ONE, in_fire & !out_ready -> FULL, skid <= in, main unchanged.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE (hold).
  - FULL, out_fire -> ONE, main <= skid. in_ready is 0, so no new capture.
  - FULL, !out_ready -> FULL (hold).
- Flush (highest priority):
  - On an edge with flush=1, next state is EMPTY and main_valid = skid_valid = 0.
  - An in_fire in the same cycle is discarded. Upstream must treat it as consumed, since in_ready was asserted.
  - out_fire in the flush cycle still counts downstream; the entry is simply not retained.
- Reset, async on rst_n low:
  - main_valid = skid_valid = 0, occupancy = 0.
  - All data/ctrl registers = 0, so out_data = 0 and out_ctrl = 0.
  - Reset asserted mid-stall drops both entries immediately without waiting for a clock.
- Data registers load only on capture, never on hold, so out_data is stable while stalled.
- Invariant: skid_valid implies main_valid.

Decomposition:
- Shared package: occupancy encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
- Shared package: per-stage CTRL bit-index constants (CTRL_REG_WRITE, CTRL_MEM_WRITE, CTRL_MEM_READ, CTRL_BRANCH_LSB, ...) so stages pack and unpack identically.
- A single sub-module is natural: pipe_entry_reg, one payload+ctrl+valid register with load enable, asynchronous active-low clear and synchronous clear. It is instantiated twice (main, skid).

Test Plan:
- Reset then stream: rst_n 0->1, out_ready=1, push data 0x11,0x22,0x33 with ctrl 0x0001 on consecutive cycles.
  - Required: the same values appear one cycle later, back-to-back.
  - Required: occupancy stays 1 and in_ready stays 1.
- Stall into skid: hold entry 0xA; drop out_ready, push 0xB.
  - Required: occupancy 2, in_ready 0, out_data 0xA held.
  - Required: after raising out_ready, outputs are 0xA then 0xB, and in_ready returns to 1.
- Bubble control zeroing: in_valid=0 with in_ctrl=0xFFFF and main empty.
  - Required: out_valid 0 and out_ctrl 0x0000.
  - Required with CLEAR_DATA=1: out_data is also 0.
- Flush while FULL with a simultaneous push of 0xC.
  - Required: next cycle occupancy 0, out_valid 0, out_ctrl 0; 0xC never appears.
- Async reset mid-stall: occupancy 2, pull rst_n low between clock edges.
  - Required: immediately out_valid 0, occupancy 0, out_data 0, in_ready 0.
  - Required: after release, in_ready is 1 without needing a clock edge.
- Randomised out_ready duty 50% over 1000 entries with incrementing data.
  - Required: the output sequence is the exact input sequence with no loss or duplication.
